// File: rtl/aes128_iter_cipher_if.sv
// Host block interface of the iterative AES-128 core.
// The o_round_key member exists only when AES_LAST_KEY_OUT_EN is defined.
interface aes128_iter_cipher_if;
    logic         i_tx_en;
    logic [127:0] i_state;
    logic [127:0] i_round_key;
    logic         o_ready;
    logic         o_tx_en;
    logic [127:0] o_state;
`ifdef AES_LAST_KEY_OUT_EN
    logic [127:0] o_round_key;
`endif

    modport master (
        output i_tx_en, i_state, i_round_key,
        input  o_ready, o_tx_en, o_state
`ifdef AES_LAST_KEY_OUT_EN
        , input o_round_key
`endif
    );

    modport slave (
        input  i_tx_en, i_state, i_round_key,
        output o_ready, o_tx_en, o_state
`ifdef AES_LAST_KEY_OUT_EN
        , output o_round_key
`endif
    );
endinterface

// File: rtl/aes128_iter_cipher.sv
// Iterative AES-128 encryption core, ROUNDS_PER_CYCLE rounds per clock with on-the-fly key expansion.
// Optional feature: AES_LAST_KEY_OUT_EN registers the round-10 key onto o_round_key.
module aes128_iter_cipher #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input logic                clock,
    input logic                reset,
    aes128_iter_cipher_if.slave bus
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam int N = 10 / R;
    localparam logic [3:0] LAST_RND = 4'(1 + (N - 1) * R);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_param
        $error("aes128_iter_cipher: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block is state[row i%4, col i/4], byte 0 in the MSBs.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = SBOX[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rcon, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [0:0]   fsm_q;
    logic [127:0] st_q, key_q, out_st_q;
    logic [7:0]   rcon_q;
    logic [3:0]   rnd_q;
    logic         tx_q;
`ifdef AES_LAST_KEY_OUT_EN
    logic [127:0] out_key_q;
`endif

    logic [127:0] st_chain  [0:R];
    logic [127:0] key_chain [0:R];
    logic [7:0]   rcon_chain[0:R];

    assign st_chain[0]   = st_q;
    assign key_chain[0]  = key_q;
    assign rcon_chain[0] = rcon_q;

    // Stage j handles round rnd_q+j; only that round equal to 10 skips MixColumns.
    for (genvar j = 0; j < R; j++) begin : g_round
        assign key_chain[j+1]  = expand_key(key_chain[j], rcon_chain[j]);
        assign rcon_chain[j+1] = xtime(rcon_chain[j]);
        assign st_chain[j+1]   = (rnd_q == 4'(10 - j))
                               ? (sub_shift(st_chain[j]) ^ key_chain[j+1])
                               : (mix_columns(sub_shift(st_chain[j])) ^ key_chain[j+1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q    <= ST_IDLE;
            st_q     <= '0;
            key_q    <= '0;
            rcon_q   <= '0;
            rnd_q    <= '0;
            tx_q     <= 1'b0;
            out_st_q <= '0;
`ifdef AES_LAST_KEY_OUT_EN
            out_key_q <= '0;
`endif
        end else begin
            tx_q <= 1'b0;
            if (fsm_q == ST_IDLE) begin
                if (bus.i_tx_en) begin
                    st_q   <= bus.i_state ^ bus.i_round_key;
                    key_q  <= bus.i_round_key;
                    rcon_q <= 8'h01;
                    rnd_q  <= 4'd1;
                    fsm_q  <= ST_RUN;
                end
            end else begin
                st_q   <= st_chain[R];
                key_q  <= key_chain[R];
                rcon_q <= rcon_chain[R];
                rnd_q  <= rnd_q + 4'(R);
                if (rnd_q == LAST_RND) begin
                    out_st_q <= st_chain[R];
                    tx_q     <= 1'b1;
                    fsm_q    <= ST_IDLE;
`ifdef AES_LAST_KEY_OUT_EN
                    out_key_q <= key_chain[R];
`endif
                end
            end
        end
    end

    assign bus.o_ready = (fsm_q == ST_IDLE);
    assign bus.o_tx_en = tx_q;
    assign bus.o_state = out_st_q;
`ifdef AES_LAST_KEY_OUT_EN
    assign bus.o_round_key = out_key_q;
`endif
endmodule

// File: tb/tb_aes128_iter_cipher.sv
// Bench for aes128_iter_cipher: four instances (1, 2, 5, 10 rounds per cycle) share one stimulus.
// Checks o_round_key too when AES_LAST_KEY_OUT_EN is defined.
module tb_aes128_iter_cipher;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         tx_en = 1'b0;
    logic [127:0] pt    = '0;
    logic [127:0] key   = '0;

    always #5 clock = ~clock;

    aes128_iter_cipher_if bus1 ();
    aes128_iter_cipher_if bus2 ();
    aes128_iter_cipher_if bus5 ();
    aes128_iter_cipher_if bus10 ();

    assign bus1.i_tx_en  = tx_en;  assign bus1.i_state  = pt;  assign bus1.i_round_key  = key;
    assign bus2.i_tx_en  = tx_en;  assign bus2.i_state  = pt;  assign bus2.i_round_key  = key;
    assign bus5.i_tx_en  = tx_en;  assign bus5.i_state  = pt;  assign bus5.i_round_key  = key;
    assign bus10.i_tx_en = tx_en;  assign bus10.i_state = pt;  assign bus10.i_round_key = key;

    aes128_iter_cipher #(.ROUNDS_PER_CYCLE(1))  dut1  (.clock(clock), .reset(reset), .bus(bus1));
    aes128_iter_cipher #(.ROUNDS_PER_CYCLE(2))  dut2  (.clock(clock), .reset(reset), .bus(bus2));
    aes128_iter_cipher #(.ROUNDS_PER_CYCLE(5))  dut5  (.clock(clock), .reset(reset), .bus(bus5));
    aes128_iter_cipher #(.ROUNDS_PER_CYCLE(10)) dut10 (.clock(clock), .reset(reset), .bus(bus10));

    logic [3:0]   done_v, ready_v;
    logic [127:0] res_v [4];
    assign done_v  = {bus10.o_tx_en, bus5.o_tx_en, bus2.o_tx_en, bus1.o_tx_en};
    assign ready_v = {bus10.o_ready, bus5.o_ready, bus2.o_ready, bus1.o_ready};
    assign res_v[0] = bus1.o_state;
    assign res_v[1] = bus2.o_state;
    assign res_v[2] = bus5.o_state;
    assign res_v[3] = bus10.o_state;

    int rs[4] = '{1, 2, 5, 10};
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] rkey;  // zero: round-10 key not checked
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_all_idle();
        for (int i = 0; i < 40; i++) begin
            if (&ready_v) return;
            @(negedge clock);
        end
        check("idle_timeout", 128'(ready_v), 128'hf);
    endtask

    // Drive a start at a negedge; the following posedge is the accepting edge.
    task automatic start_job(input logic [127:0] p, input logic [127:0] k);
        pt = p;
        key = k;
        tx_en = 1'b1;
        @(negedge clock);
        tx_en = 1'b0;
        pt = '1;
        key = '1;
    endtask

    // k counts edges since the accepting edge; a result from N rounds shows up at k == N.
    task automatic run_job(input vec_t v, input string tag);
        int           lat[4];
        logic [127:0] res[4];
`ifdef AES_LAST_KEY_OUT_EN
        logic [127:0] rk1;
        rk1 = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            res[i] = '0;
        end
        wait_all_idle();
        start_job(v.pt, v.key);
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (done_v[i] && lat[i] < 0) begin
                    lat[i] = k;
                    res[i] = res_v[i];
`ifdef AES_LAST_KEY_OUT_EN
                    if (i == 0) rk1 = bus1.o_round_key;
`endif
                end
            end
            @(negedge clock);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lat_r%0d", tag, rs[i]), 128'(lat[i]), 128'(10 / rs[i]));
            check($sformatf("%s_ct_r%0d", tag, rs[i]), res[i], v.ct);
        end
`ifdef AES_LAST_KEY_OUT_EN
        if (v.rkey != '0) begin
            check({tag, "_rkey_r1"}, rk1, v.rkey);
            check({tag, "_rkey_r10"}, bus10.o_round_key, v.rkey);
        end
`endif
    endtask

    initial begin
        int           pulses, lat, t1, t2;
        logic [127:0] got, got2;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

        repeat (3) @(negedge clock);
        check("rst_ready", 128'(ready_v), 128'hf);
        check("rst_tx_en", 128'(done_v), 128'h0);
        check("rst_state_r1", bus1.o_state, '0);
        check("rst_state_r10", bus10.o_state, '0);
`ifdef AES_LAST_KEY_OUT_EN
        check("rst_rkey", bus1.o_round_key, '0);
`endif
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 3; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Starts while busy must be ignored.
        wait_all_idle();
        start_job(vecs[0].pt, vecs[0].key);
        pulses = 0;
        lat = -1;
        got = '0;
        for (int k = 0; k < 14; k++) begin
            if (bus1.o_tx_en) begin
                pulses++;
                lat = k;
                got = bus1.o_state;
            end
            if (k == 5) check("busy_ready", 128'(bus1.o_ready), 128'h0);
            if (bus1.o_ready) begin
                tx_en = 1'b0;
            end else begin
                tx_en = 1'b1;
                pt = vecs[1].pt ^ 128'(k);
                key = vecs[1].key;
            end
            @(negedge clock);
        end
        tx_en = 1'b0;
        check("busy_pulses", 128'(pulses), 128'd1);
        check("busy_lat", 128'(lat), 128'd10);
        check("busy_ct", got, vecs[0].ct);
        check("busy_held", bus1.o_state, vecs[0].ct);

        // Back-to-back: second start in the completion cycle.
        wait_all_idle();
        start_job(vecs[0].pt, vecs[0].key);
        t1 = -1;
        t2 = -1;
        got = '0;
        got2 = '0;
        for (int k = 0; k < 30; k++) begin
            tx_en = 1'b0;
            if (bus1.o_tx_en) begin
                if (t1 < 0) begin
                    t1 = k;
                    got = bus1.o_state;
                    check("b2b_ready_with_tx", 128'(bus1.o_ready), 128'h1);
                    pt = vecs[1].pt;
                    key = vecs[1].key;
                    tx_en = 1'b1;
                end else if (t2 < 0) begin
                    t2 = k;
                    got2 = bus1.o_state;
                end
            end
            @(negedge clock);
        end
        tx_en = 1'b0;
        check("b2b_t1", 128'(t1), 128'd10);
        check("b2b_gap", 128'(t2 - t1), 128'd11);
        check("b2b_ct1", got, vecs[0].ct);
        check("b2b_ct2", got2, vecs[1].ct);

        // Reset during RUN aborts the job.
        wait_all_idle();
        start_job(vecs[0].pt, vecs[0].key);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_ready", 128'(bus1.o_ready), 128'h1);
        check("abort_tx_en", 128'(bus1.o_tx_en), 128'h0);
        check("abort_state", bus1.o_state, '0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus1.o_tx_en) pulses++;
            @(negedge clock);
        end
        check("abort_no_tx", 128'(pulses), 128'd0);
        run_job(vecs[1], "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
